lfsr_gen: RTL and testbench



---
 rtl/lfsr_gen_pkg.sv | 121 ++++++++++++
 rtl/lfsr_gen.sv | 89 ++++++++
 tb/tb_lfsr_gen.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_gen_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg : shared helpers for the XNOR-form Fibonacci LFSR (lfsr_gen).
//   lfsr_taps(width)     - 64-bit tap mask, bit n-1 set for tap n
//                          (maximal-length table, widths 3..64)
//   lfsr_mask(width)     - 64-bit mask of the low 'width' bits
//   lfsr_shift(v, width) - one XNOR shift: {v[width-2:0], fb}, upper bits zero
// -----------------------------------------------------------------------------
package lfsr_pkg;

   localparam int LFSR_MAX_WIDTH = 64;

   // Sets bit n-1 for each non-zero tap number n.
   function automatic logic [LFSR_MAX_WIDTH-1:0] taps4(input int a, input int b,
                                                       input int c, input int d);
      logic [LFSR_MAX_WIDTH-1:0] m;
      m = '0;
      if (a > 0) m[a-1] = 1'b1;
      if (b > 0) m[b-1] = 1'b1;
      if (c > 0) m[c-1] = 1'b1;
      if (d > 0) m[d-1] = 1'b1;
      return m;
   endfunction

   function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_taps(input int width);
      logic [LFSR_MAX_WIDTH-1:0] m;
      case (width)
         3:  m = taps4(3, 2, 0, 0);
         4:  m = taps4(4, 3, 0, 0);
         5:  m = taps4(5, 3, 0, 0);
         6:  m = taps4(6, 5, 0, 0);
         7:  m = taps4(7, 6, 0, 0);
         8:  m = taps4(8, 6, 5, 4);
         9:  m = taps4(9, 5, 0, 0);
         10: m = taps4(10, 7, 0, 0);
         11: m = taps4(11, 9, 0, 0);
         12: m = taps4(12, 6, 4, 1);
         13: m = taps4(13, 4, 3, 1);
         14: m = taps4(14, 5, 3, 1);
         15: m = taps4(15, 14, 0, 0);
         16: m = taps4(16, 15, 13, 4);
         17: m = taps4(17, 14, 0, 0);
         18: m = taps4(18, 11, 0, 0);
         19: m = taps4(19, 6, 2, 1);
         20: m = taps4(20, 17, 0, 0);
         21: m = taps4(21, 19, 0, 0);
         22: m = taps4(22, 21, 0, 0);
         23: m = taps4(23, 18, 0, 0);
         24: m = taps4(24, 23, 22, 17);
         25: m = taps4(25, 22, 0, 0);
         26: m = taps4(26, 6, 2, 1);
         27: m = taps4(27, 5, 2, 1);
         28: m = taps4(28, 25, 0, 0);
         29: m = taps4(29, 27, 0, 0);
         30: m = taps4(30, 6, 4, 1);
         31: m = taps4(31, 28, 0, 0);
         32: m = taps4(32, 22, 2, 1);
         33: m = taps4(33, 20, 0, 0);
         34: m = taps4(34, 27, 2, 1);
         35: m = taps4(35, 33, 0, 0);
         36: m = taps4(36, 25, 0, 0);
         37: m = taps4(37, 5, 4, 3) | taps4(2, 1, 0, 0);
         38: m = taps4(38, 6, 5, 1);
         39: m = taps4(39, 35, 0, 0);
         40: m = taps4(40, 38, 21, 19);
         41: m = taps4(41, 38, 0, 0);
         42: m = taps4(42, 41, 20, 19);
         43: m = taps4(43, 42, 38, 37);
         44: m = taps4(44, 43, 18, 17);
         45: m = taps4(45, 44, 42, 41);
         46: m = taps4(46, 45, 26, 25);
         47: m = taps4(47, 42, 0, 0);
         48: m = taps4(48, 47, 21, 20);
         49: m = taps4(49, 40, 0, 0);
         50: m = taps4(50, 49, 24, 23);
         51: m = taps4(51, 50, 36, 35);
         52: m = taps4(52, 49, 0, 0);
         53: m = taps4(53, 52, 38, 37);
         54: m = taps4(54, 53, 18, 17);
         55: m = taps4(55, 31, 0, 0);
         56: m = taps4(56, 55, 35, 34);
         57: m = taps4(57, 50, 0, 0);
         58: m = taps4(58, 39, 0, 0);
         59: m = taps4(59, 58, 38, 37);
         60: m = taps4(60, 59, 0, 0);
         61: m = taps4(61, 60, 46, 45);
         62: m = taps4(62, 61, 6, 5);
         63: m = taps4(63, 62, 0, 0);
         64: m = taps4(64, 63, 61, 60);
         default: m = '0;
      endcase
      return m;
   endfunction

   function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_mask(input int width);
      logic [LFSR_MAX_WIDTH-1:0] ones;
      ones = '1;
      return ones >> (LFSR_MAX_WIDTH - width);
   endfunction

   // XNOR chain over the tapped bits, highest tap first.
   function automatic logic [LFSR_MAX_WIDTH-1:0] lfsr_shift(input logic [LFSR_MAX_WIDTH-1:0] v,
                                                            input int width);
      logic [LFSR_MAX_WIDTH-1:0] taps;
      logic                      fb;
      logic                      first;
      int unsigned               idx;
      taps  = lfsr_taps(width);
      fb    = 1'b0;
      first = 1'b1;
      for (int unsigned k = 0; k < LFSR_MAX_WIDTH; k++) begin
         idx = (LFSR_MAX_WIDTH - 1) - k;
         if (taps[idx]) begin
            if (first) fb = v[idx];
            else       fb = fb ^~ v[idx];
            first = 1'b0;
         end
      end
      return ((v << 1) | {{(LFSR_MAX_WIDTH-1){1'b0}}, fb}) & lfsr_mask(width);
   endfunction

endpackage

// File: rtl/lfsr_gen.sv
// -----------------------------------------------------------------------------
// lfsr_gen : parametrised XNOR-form Fibonacci LFSR, STEP shifts per enable.
//   Parameters: WIDTH (3..64), STEP (1..WIDTH), INIT_STATE (not all-ones).
//   Ports:
//     clk        clock
//     rst        asynchronous active-high reset
//     enable     advance by STEP shifts this cycle
//     seed_load  load 'seed' this cycle (priority over enable)
//     seed       seed value; all-ones is rejected and INIT_STATE used instead
//     value      current state (registered)
//     seed_err   one-cycle pulse after a rejected seed
//     wrapped    one-cycle pulse after an advance that lands on INIT_STATE
//     adv_count  (only with LFSR_GEN_ADV_CNT_EN) shifts since last load/reset
//   Optional feature macro: LFSR_GEN_ADV_CNT_EN
// -----------------------------------------------------------------------------
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int               WIDTH      = 32,
   parameter int               STEP       = 1,
   parameter logic [WIDTH-1:0] INIT_STATE = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enable,
   input  logic             seed_load,
   input  logic [WIDTH-1:0] seed,
   output logic [WIDTH-1:0] value,
   output logic             seed_err,
`ifdef LFSR_GEN_ADV_CNT_EN
   output logic [63:0]      adv_count,
`endif
   output logic             wrapped
);

   if (WIDTH < 3 || WIDTH > LFSR_MAX_WIDTH) begin : g_bad_width
      $fatal(1, "lfsr_gen: WIDTH must be 3..64");
   end
   if (STEP < 1 || STEP > WIDTH) begin : g_bad_step
      $fatal(1, "lfsr_gen: STEP must be 1..WIDTH");
   end
   if (INIT_STATE == {WIDTH{1'b1}}) begin : g_bad_init
      $fatal(1, "lfsr_gen: INIT_STATE must not be the all-ones lock-up state");
   end

   // Combinational unroll: stage[i] is the state after i single shifts.
   logic [WIDTH-1:0] stage [STEP+1];
   logic [WIDTH-1:0] adv_value;
   logic             seed_bad;

   assign stage[0] = value;
   for (genvar gi = 0; gi < STEP; gi++) begin : g_step
      assign stage[gi+1] = WIDTH'(lfsr_shift(LFSR_MAX_WIDTH'(stage[gi]), WIDTH));
   end
   assign adv_value = stage[STEP];
   assign seed_bad  = (seed == {WIDTH{1'b1}});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         value    <= INIT_STATE;
         seed_err <= 1'b0;
         wrapped  <= 1'b0;
`ifdef LFSR_GEN_ADV_CNT_EN
         adv_count <= '0;
`endif
      end else begin
         seed_err <= 1'b0;
         wrapped  <= 1'b0;
         if (seed_load) begin
            if (seed_bad) begin
               value    <= INIT_STATE;
               seed_err <= 1'b1;
            end else begin
               value <= seed;
            end
`ifdef LFSR_GEN_ADV_CNT_EN
            adv_count <= '0;
`endif
         end else if (enable) begin
            value   <= adv_value;
            wrapped <= (adv_value == INIT_STATE);
`ifdef LFSR_GEN_ADV_CNT_EN
            adv_count <= adv_count + 64'(STEP);
`endif
         end
      end
   end

endmodule

// File: tb/tb_lfsr_gen.sv
// -----------------------------------------------------------------------------
// tb_lfsr_gen : self-checking bench for lfsr_gen. Five instances share the
// control inputs; each is tracked by a behavioural model. The 32-bit STEP=1
// instance is additionally checked against a hand-computed vector table.
// -----------------------------------------------------------------------------
module tb_lfsr_gen;

   localparam int N = 5;
   localparam int          W_T    [N] = '{32, 32, 4, 8, 16};
   localparam int          S_T    [N] = '{1, 2, 1, 1, 3};
   localparam logic [63:0] INIT_T [N] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'hA5};

   logic        clk;
   logic        rst;
   logic        enable;
   logic        seed_load;
   logic [63:0] seed_bus;

   logic [31:0] v0, v1;
   logic [3:0]  v2;
   logic [7:0]  v3;
   logic [15:0] v4;
   logic        err  [N];
   logic        wrap [N];
   logic [63:0] cnt  [N];
   logic [63:0] dv   [N];

   int n_chk  = 0;
   int n_fail = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   lfsr_gen #(.WIDTH(32), .STEP(1), .INIT_STATE(32'h0)) u0 (
      .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
      .seed(seed_bus[31:0]), .value(v0), .seed_err(err[0]),
`ifdef LFSR_GEN_ADV_CNT_EN
      .adv_count(cnt[0]),
`endif
      .wrapped(wrap[0]));
   lfsr_gen #(.WIDTH(32), .STEP(2), .INIT_STATE(32'h0)) u1 (
      .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
      .seed(seed_bus[31:0]), .value(v1), .seed_err(err[1]),
`ifdef LFSR_GEN_ADV_CNT_EN
      .adv_count(cnt[1]),
`endif
      .wrapped(wrap[1]));
   lfsr_gen #(.WIDTH(4), .STEP(1), .INIT_STATE(4'h0)) u2 (
      .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
      .seed(seed_bus[3:0]), .value(v2), .seed_err(err[2]),
`ifdef LFSR_GEN_ADV_CNT_EN
      .adv_count(cnt[2]),
`endif
      .wrapped(wrap[2]));
   lfsr_gen #(.WIDTH(8), .STEP(1), .INIT_STATE(8'h0)) u3 (
      .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
      .seed(seed_bus[7:0]), .value(v3), .seed_err(err[3]),
`ifdef LFSR_GEN_ADV_CNT_EN
      .adv_count(cnt[3]),
`endif
      .wrapped(wrap[3]));
   lfsr_gen #(.WIDTH(16), .STEP(3), .INIT_STATE(16'h00A5)) u4 (
      .clk(clk), .rst(rst), .enable(enable), .seed_load(seed_load),
      .seed(seed_bus[15:0]), .value(v4), .seed_err(err[4]),
`ifdef LFSR_GEN_ADV_CNT_EN
      .adv_count(cnt[4]),
`endif
      .wrapped(wrap[4]));

   assign dv[0] = 64'(v0);
   assign dv[1] = 64'(v1);
   assign dv[2] = 64'(v2);
   assign dv[3] = 64'(v3);
   assign dv[4] = 64'(v4);

   // ---------------- behavioural model ----------------
   logic [63:0] mv   [N];
   bit          merr [N];
   bit          mwrap[N];
   logic [63:0] mcnt [N];

   function automatic logic [63:0] wmask(input int w);
      return (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
   endfunction

   // One shift: a left-to-right XNOR chain over n taps is their parity
   // inverted n-1 times.
   function automatic logic [63:0] m_shift(input logic [63:0] v, input int w);
      int taps[$];
      int ones;
      bit fb;
      case (w)
         4:  taps = '{4, 3};
         8:  taps = '{8, 6, 5, 4};
         16: taps = '{16, 15, 13, 4};
         default: taps = '{32, 22, 2, 1};
      endcase
      ones = 0;
      foreach (taps[i]) ones += int'(v[taps[i]-1]);
      fb = ((ones + taps.size() - 1) % 2) == 1;
      return ((v << 1) | 64'(fb)) & wmask(w);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         mv[i] = INIT_T[i]; merr[i] = 0; mwrap[i] = 0; mcnt[i] = 0;
      end
   endtask

   task automatic model_clock(input bit en, input bit ld, input logic [63:0] sb);
      logic [63:0] s;
      for (int i = 0; i < N; i++) begin
         merr[i] = 0; mwrap[i] = 0;
         if (ld) begin
            s = sb & wmask(W_T[i]);
            if (s == wmask(W_T[i])) begin mv[i] = INIT_T[i]; merr[i] = 1; end
            else mv[i] = s;
            mcnt[i] = 0;
         end else if (en) begin
            for (int k = 0; k < S_T[i]; k++) mv[i] = m_shift(mv[i], W_T[i]);
            mwrap[i] = (mv[i] == INIT_T[i]);
            mcnt[i]  = mcnt[i] + 64'(S_T[i]);
         end
      end
   endtask

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_all(input int first);
      for (int i = first; i < N; i++) begin
         chk($sformatf("u%0d value", i), dv[i], mv[i]);
         chk($sformatf("u%0d seed_err", i), 64'(err[i]), 64'(merr[i]));
         chk($sformatf("u%0d wrapped", i), 64'(wrap[i]), 64'(mwrap[i]));
`ifdef LFSR_GEN_ADV_CNT_EN
         chk($sformatf("u%0d adv_count", i), cnt[i], mcnt[i]);
`endif
      end
   endtask

   task automatic cyc(input bit en, input bit ld, input logic [63:0] sb);
      enable = en; seed_load = ld; seed_bus = sb;
      @(posedge clk);
      model_clock(en, ld, sb);
      #1;
   endtask

   // Async reset asserted mid-cycle, checked before any clock edge.
   task automatic async_reset();
      rst = 1'b1;
      #1;
      model_reset();
      check_all(0);
      #2;
      rst = 1'b0;
   endtask

   typedef struct {
      bit          en;
      bit          ld;
      logic [31:0] seed;
      logic [31:0] val;
      bit          err;
      bit          wrap;
   } vec_t;

   vec_t tbl [9];
   bit   seen4 [16];
   bit   seen8 [256];

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0] = '{1, 0, 32'h0,        32'h0000_0001, 0, 0};
      tbl[1] = '{1, 0, 32'h0,        32'h0000_0002, 0, 0};
      tbl[2] = '{1, 0, 32'h0,        32'h0000_0004, 0, 0};
      tbl[3] = '{1, 1, 32'hFFFF_FFFF, 32'h0000_0000, 1, 0};
      tbl[4] = '{0, 0, 32'h0,        32'h0000_0000, 0, 0};
      tbl[5] = '{1, 1, 32'h1234_5678, 32'h1234_5678, 0, 0};
      tbl[6] = '{1, 0, 32'h0,        32'h2468_ACF0, 0, 0};
      tbl[7] = '{0, 1, 32'h0,        32'h0000_0000, 0, 0};
      tbl[8] = '{1, 0, 32'h0,        32'h0000_0001, 0, 0};

      rst = 1'b1; enable = 1'b0; seed_load = 1'b0; seed_bus = '0;
      #12;
      model_reset();
      check_all(0);
      chk("reset u0 value", dv[0], 64'h0);
      rst = 1'b0;

      // Vector table on the 32-bit single-step instance.
      for (int k = 0; k < 9; k++) begin
         cyc(tbl[k].en, tbl[k].ld, {tbl[k].seed, tbl[k].seed});
         chk($sformatf("tbl%0d value", k), dv[0], 64'(tbl[k].val));
         chk($sformatf("tbl%0d seed_err", k), 64'(err[0]), 64'(tbl[k].err));
         chk($sformatf("tbl%0d wrapped", k), 64'(wrap[0]), 64'(tbl[k].wrap));
         if (k == 0) chk("step2 first advance", dv[1], 64'h2);
         check_all(1);
      end

      // Full period: WIDTH=4 every 15 advances, WIDTH=8 once in 255.
      async_reset();
      for (int j = 0; j < 255; j++) begin
         cyc(1, 0, '0);
         check_all(0);
         chk($sformatf("w4 wrap @%0d", j), 64'(wrap[2]), 64'(((j + 1) % 15) == 0));
         chk($sformatf("w8 wrap @%0d", j), 64'(wrap[3]), 64'(j == 254));
         if (j < 15) begin
            chk($sformatf("w4 unique @%0d", j), 64'(seen4[v2]), 64'h0);
            seen4[v2] = 1;
         end
         chk($sformatf("w8 unique @%0d", j), 64'(seen8[v3]), 64'h0);
         seen8[v3] = 1;
      end
      chk("w4 not lockup", 64'(seen4[15]), 64'h0);
      chk("w8 not lockup", 64'(seen8[255]), 64'h0);

      // Reset mid-run with a pending seed_err, then with advanced state.
      async_reset();
      for (int j = 0; j < 3; j++) begin cyc(1, 0, '0); check_all(0); end
      cyc(1, 1, '1);
      check_all(0);
      chk("lockup seed_err", 64'(err[0]), 64'h1);
      async_reset();
      for (int j = 0; j < 2; j++) begin cyc(1, 0, '0); check_all(0); end
      async_reset();
      for (int j = 0; j < 2; j++) begin cyc(1, 0, '0); check_all(0); end

      // Randomised traffic against the model.
      for (int j = 0; j < 400; j++) begin
         logic [63:0] sb;
         sb = ($urandom_range(0, 3) == 0) ? 64'hFFFF_FFFF_FFFF_FFFF
                                          : {$urandom, $urandom};
         cyc($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, sb);
         check_all(0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
